// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed, checksummed program image from a
// valid/ready byte source into program memory, holding the CPU in reset
// until the image has been fully written and its checksum verified.
//
// Stream format: L (0 means 256), L image bytes, checksum C.
// The image is accepted when (sum of image bytes + C) mod 256 == 0.
module prog_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         DATA_W    = 8
) (
    input  logic              ph1,
    input  logic              reset,
    input  logic              load_req,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [7:0]        mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_LOAD  = 3'd2,
        S_CHECK = 3'd3,
        S_RUN   = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_len;
    logic [7:0]  r_idx;
    logic [7:0]  r_sum;

    logic        r_in_ready;
    logic        r_mem_we;
    logic [7:0]  r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_cpu_reset;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic        w_hs;
    logic        w_last;
    logic [7:0]  w_len_m1;
    logic [7:0]  w_sum_nx;
    logic        w_busy_nx;

    // A byte moves only when the source offers it and we advertised ready.
    assign w_hs      = in_valid & r_in_ready;
    // L=0 encodes 256: L-1 wraps to 8'hFF, which the 8-bit index reaches on byte 256.
    assign w_len_m1  = r_len - 8'd1;
    assign w_last    = (r_idx == w_len_m1);
    // Running sum including the byte currently on in_data; in CHECK this is sum + C.
    assign w_sum_nx  = r_sum + in_data;
    assign w_busy_nx = (w_next == S_LEN) || (w_next == S_LOAD) || (w_next == S_CHECK);

    // State register.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; load_req is only honoured when no load is in flight.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (load_req) w_next = S_LEN;
                else          w_next = S_IDLE;
            end
            S_LEN: begin
                if (w_hs) w_next = S_LOAD;
                else      w_next = S_LEN;
            end
            S_LOAD: begin
                if (w_hs && w_last) w_next = S_CHECK;
                else                w_next = S_LOAD;
            end
            S_CHECK: begin
                if (w_hs) begin
                    if (w_sum_nx == 8'd0) w_next = S_RUN;
                    else                  w_next = S_ERROR;
                end else begin
                    w_next = S_CHECK;
                end
            end
            S_RUN: begin
                if (load_req) w_next = S_LEN;
                else          w_next = S_RUN;
            end
            S_ERROR: begin
                if (load_req) w_next = S_LEN;
                else          w_next = S_ERROR;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Status outputs registered from the next state so they track the state exactly.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_reset <= 1'b1;
        end else begin
            r_in_ready  <= w_busy_nx;
            r_busy      <= w_busy_nx;
            r_done      <= (w_next == S_RUN);
            r_err       <= (w_next == S_ERROR);
            r_cpu_reset <= (w_next != S_RUN);
        end
    end

    // Length/index/sum tracking and the one-cycle memory write per image byte.
    always_ff @(posedge ph1 or posedge reset) begin
        if (reset) begin
            r_len       <= 8'd0;
            r_idx       <= 8'd0;
            r_sum       <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= BASE_ADDR;
            r_mem_wdata <= 8'd0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_LEN: begin
                    if (w_hs) begin
                        r_len <= in_data;
                        r_idx <= 8'd0;
                        r_sum <= 8'd0;
                    end
                end
                S_LOAD: begin
                    if (w_hs) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= BASE_ADDR + r_idx;
                        r_mem_wdata <= in_data;
                        r_sum       <= w_sum_nx;
                        r_idx       <= r_idx + 8'd1;
                    end
                end
                default: begin
                    // Length and checksum bytes never write memory.
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_reset = r_cpu_reset;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
